// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, method tags and message layout for the serializer pipe
package pipe_pkg;
  localparam int PIPE_WIDTH = 128;
  localparam int TAG_LSB = 0;
  localparam int TAG_MSB = 31;
  localparam logic [31:0] TAG_SAY2 = 32'd1;
  localparam logic [31:0] TAG_HEARD2 = 32'd1;
  localparam logic [31:0] TAG_SAY = 32'd2;
  localparam logic [31:0] TAG_HEARD = 32'd2;
  typedef struct packed {
    logic [31:0] v2;
    logic [31:0] v;
    logic [31:0] meth;
    logic [31:0] tag;
  } pipe_msg_t;
endpackage

// File: rtl/pipe_fifo_mem.sv
// pipe_fifo_mem: DEPTH x WIDTH register file, sync write, async read, no reset
module pipe_fifo_mem #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/pipe_fifo_stage.sv
// pipe_fifo_stage: elastic push-style FIFO between a pipe serializer and deserializer
module pipe_fifo_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   in_enq__ENA,
  input  logic [WIDTH-1:0]       in_enq_v,
  output logic                   in_enq__RDY,
  output logic                   out_enq__ENA,
  output logic [WIDTH-1:0]       out_enq_v,
  input  logic                   out_enq__RDY,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_overflow
);
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic err_q, err_d;
  logic enq, deq;
  always_comb begin
    in_enq__RDY = count_q != CNTW'(DEPTH);
    out_enq__ENA = (count_q != '0) & out_enq__RDY;
    enq = in_enq__ENA & in_enq__RDY;
    deq = out_enq__ENA;
    wptr_d = enq ? wptr_q + 1'b1 : wptr_q;
    rptr_d = deq ? rptr_q + 1'b1 : rptr_q;
    count_d = (enq & ~deq) ? count_q + 1'b1 : (deq & ~enq) ? count_q - 1'b1 : count_q;
    err_d = err_q | (in_enq__ENA & ~in_enq__RDY);
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rptr_q <= '0;
      wptr_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  end
  assign count = count_q;
  assign err_overflow = err_q;
  pipe_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(CLK),
    .we(enq),
    .waddr(wptr_q),
    .wdata(in_enq_v),
    .raddr(rptr_q),
    .rdata(out_enq_v)
  );
endmodule

// File: tb/tb_pipe_fifo_stage.sv
// tb_pipe_fifo_stage: randomized scoreboard bench for pipe_fifo_stage
module tb_pipe_fifo_stage;
  import pipe_pkg::*;
  localparam int DEPTH = 4;
  logic CLK, nRST;
  logic in_ena, in_rdy, out_ena, out_rdy, err;
  logic [127:0] in_v, out_v;
  logic [2:0] cnt;
  int total = 0;
  int bad = 0;
  int mcnt = 0;
  logic merr = 1'b0;
  logic [127:0] exp_q[$];
  pipe_fifo_stage #(.WIDTH(128), .DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .in_enq__ENA(in_ena),
    .in_enq_v(in_v),
    .in_enq__RDY(in_rdy),
    .out_enq__ENA(out_ena),
    .out_enq_v(out_v),
    .out_enq__RDY(out_rdy),
    .count(cnt),
    .err_overflow(err)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  always @(negedge CLK) begin
    if (nRST && out_ena) begin
      if (exp_q.size() == 0) chk("unexpected_output", 128'd1, 128'd0);
      else chk("out_data", out_v, exp_q.pop_front());
    end
  end
  task automatic step(input logic e, input logic [127:0] d, input logic r);
    logic acc, rel;
    in_ena = e;
    in_v = d;
    out_rdy = r;
    @(negedge CLK);
    chk("in_rdy", 128'(in_rdy), 128'(mcnt != DEPTH));
    chk("out_ena", 128'(out_ena), 128'(mcnt != 0 && r));
    chk("count", 128'(cnt), 128'(mcnt));
    chk("err_overflow", 128'(err), 128'(merr));
    @(posedge CLK);
    acc = e && mcnt != DEPTH;
    rel = mcnt != 0 && r;
    if (e && mcnt == DEPTH) merr = 1'b1;
    if (acc) exp_q.push_back(d);
    mcnt = mcnt + int'(acc) - int'(rel);
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, rnd(), 1'b1);
  endtask
  initial begin
    pipe_msg_t m;
    nRST = 1'b0;
    in_ena = 1'b0;
    in_v = '0;
    out_rdy = 1'b1;
    #3;
    chk("rst_count", 128'(cnt), 128'd0);
    chk("rst_rdy", 128'(in_rdy), 128'd1);
    chk("rst_ena", 128'(out_ena), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    m = '{v2: 32'd0, v: 32'h55, meth: 32'd7, tag: TAG_SAY};
    step(1'b1, m, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd(), 1'b0);
    step(1'b0, '0, 1'b0);
    drain();
    step(1'b1, rnd(), 1'b0);
    step(1'b1, rnd(), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, rnd(), 1'b1);
    drain();
    for (int i = 0; i < 40; i++) step(i % 2 == 0 && mcnt != DEPTH, rnd(), i % 2 == 1);
    drain();
    for (int i = 0; i < 200; i++) step($urandom_range(0, 1) == 1 && mcnt != DEPTH, rnd(), $urandom_range(0, 2) != 0);
    drain();
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd(), 1'b0);
    step(1'b1, rnd(), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b0);
    in_ena = 1'b0;
    out_rdy = 1'b1;
    #1 nRST = 1'b0;
    #1;
    chk("midrst_count", 128'(cnt), 128'd0);
    chk("midrst_ena", 128'(out_ena), 128'd0);
    chk("midrst_rdy", 128'(in_rdy), 128'd1);
    chk("midrst_err", 128'(err), 128'd0);
    mcnt = 0;
    merr = 1'b0;
    exp_q.delete();
    @(posedge CLK);
    #1 nRST = 1'b1;
    step(1'b1, rnd(), 1'b1);
    drain();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
